// File: rtl/slice_column_sequencer.sv
// ==== slice_column_sequencer : per-frame column sweep (ray issue, fishbowl fix, wall height) ====
// ==== rev 1.0                                                                                 ====
`default_nettype none

module slice_column_sequencer #(
    parameter int NUM_COLS   = 160,
    parameter int COL_W      = 8,
    parameter int ANGLE_FRAC = 8,
    parameter int ANGLE_W    = 17,
    parameter int FOV_DEG    = 60,
    parameter int DIST_W     = 21,
    parameter int COS_FRAC   = 8,
    parameter int PROJ_CONST = 8896,
    parameter int PROJ_W     = 14,
    parameter int SCREEN_H   = 120,
    parameter int HEIGHT_W   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ANGLE_W-1:0]    player_angle,
    output logic                  busy,
    output logic                  done,
    output logic                  ray_valid,
    input  logic                  ray_ready,
    output logic [ANGLE_W-1:0]    ray_angle,
    output logic [COL_W-1:0]      ray_col,
    input  logic                  hit_valid,
    input  logic [DIST_W-1:0]     hit_dist_h,
    input  logic [DIST_W-1:0]     hit_dist_v,
    output logic [ANGLE_W-1:0]    beta_angle,
    input  logic [COS_FRAC:0]     cos_value,
    output logic                  slice_valid,
    input  logic                  slice_ready,
    output logic [COL_W-1:0]      slice_col,
    output logic [HEIGHT_W-1:0]   slice_height,
    output logic [HEIGHT_W-1:0]   slice_top
);

    localparam int STEP = FOV_DEG * (2 ** ANGLE_FRAC) / NUM_COLS;
    localparam int HALF = (FOV_DEG / 2) << ANGLE_FRAC;
    localparam int FULL = 360 << ANGLE_FRAC;
    localparam int AW2  = ANGLE_W + 2;
    localparam int PW   = DIST_W + COS_FRAC + 1;
    localparam int IW   = $clog2(PROJ_W);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CORRECT = 3'd3;
    localparam logic [2:0] S_DIVIDE  = 3'd4;
    localparam logic [2:0] S_EMIT    = 3'd5;

    logic [2:0]           state, state_next;
    logic [ANGLE_W-1:0]   pa;
    logic [COL_W-1:0]     col;
    logic [DIST_W-1:0]    dmin;
    logic [DIST_W:0]      divisor;
    logic [DIST_W:0]      rem;
    logic [PROJ_W-1:0]    quo;
    logic [IW-1:0]        iter;
    logic                 div_zero;

    logic [COL_W-1:0]     sel_col;
    logic [ANGLE_W-1:0]   sel_pa;
    logic [AW2-1:0]       col_off;
    logic [AW2-1:0]       raw;
    logic [ANGLE_W-1:0]   next_angle;
    logic [PW-1:0]        prod;
    logic [DIST_W:0]      corr;
    logic [DIST_W+1:0]    rem_sh;
    logic                 ge;
    logic [PROJ_W-1:0]    quo_next;
    logic [HEIGHT_W-1:0]  height_next;
    logic [HEIGHT_W-1:0]  top_next;
    logic                 last_col;
    logic                 last_iter;

    assign last_col  = (col == COL_W'(NUM_COLS - 1));
    assign last_iter = (iter == IW'(PROJ_W - 1));

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start)       state_next = S_ISSUE;
            S_ISSUE:   if (ray_ready)   state_next = S_WAIT;
            S_WAIT:    if (hit_valid)   state_next = S_CORRECT;
            S_CORRECT:                  state_next = S_DIVIDE;
            S_DIVIDE:  if (last_iter)   state_next = S_EMIT;
            S_EMIT:    if (slice_ready) state_next = last_col ? S_IDLE : S_ISSUE;
            default:                    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != S_IDLE);
        ray_valid   = (state == S_ISSUE);
        slice_valid = (state == S_EMIT);
    end

    // Angle of the column about to be issued: column 0 from the live input on
    // start, otherwise the following column from the latched heading.
    always_comb begin
        sel_col = (state == S_IDLE) ? '0 : col + 1'b1;
        sel_pa  = (state == S_IDLE) ? player_angle : pa;
        col_off = AW2'(sel_col) * AW2'(STEP);
        raw     = AW2'(sel_pa) + AW2'(HALF) - col_off;
        if (raw[AW2-1])
            next_angle = raw[ANGLE_W-1:0] + ANGLE_W'(FULL);
        else if (raw >= AW2'(FULL))
            next_angle = raw[ANGLE_W-1:0] - ANGLE_W'(FULL);
        else
            next_angle = raw[ANGLE_W-1:0];
    end

    assign beta_angle = ANGLE_W'(col) * ANGLE_W'(STEP) - ANGLE_W'(HALF);

    always_comb begin
        prod        = PW'(dmin) * PW'(cos_value);
        corr        = (DIST_W + 1)'(prod >> COS_FRAC);
        rem_sh      = {rem, quo[PROJ_W-1]};
        ge          = (rem_sh >= {1'b0, divisor});
        quo_next    = {quo[PROJ_W-2:0], ge};
        if (div_zero || (quo_next > PROJ_W'(SCREEN_H)))
            height_next = HEIGHT_W'(SCREEN_H);
        else
            height_next = quo_next[HEIGHT_W-1:0];
        top_next    = (HEIGHT_W'(SCREEN_H) - height_next) >> 1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pa           <= '0;
            col          <= '0;
            ray_angle    <= '0;
            ray_col      <= '0;
            dmin         <= '0;
            divisor      <= '0;
            div_zero     <= 1'b0;
            rem          <= '0;
            quo          <= '0;
            iter         <= '0;
            slice_col    <= '0;
            slice_height <= '0;
            slice_top    <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    pa        <= player_angle;
                    col       <= '0;
                    ray_angle <= next_angle;
                    ray_col   <= '0;
                end
                S_WAIT: if (hit_valid) begin
                    dmin <= (hit_dist_v < hit_dist_h) ? hit_dist_v : hit_dist_h;
                end
                S_CORRECT: begin
                    divisor  <= corr;
                    div_zero <= (corr == '0);
                    rem      <= '0;
                    quo      <= PROJ_W'(PROJ_CONST);
                    iter     <= '0;
                end
                S_DIVIDE: begin
                    // Dividend bits shift out of quo as quotient bits shift in.
                    rem  <= ge ? (DIST_W + 1)'(rem_sh - {1'b0, divisor})
                               : (DIST_W + 1)'(rem_sh);
                    quo  <= quo_next;
                    iter <= iter + 1'b1;
                    if (last_iter) begin
                        slice_col    <= col;
                        slice_height <= height_next;
                        slice_top    <= top_next;
                    end
                end
                S_EMIT: if (slice_ready) begin
                    if (last_col) begin
                        done <= 1'b1;
                    end else begin
                        col       <= col + 1'b1;
                        ray_col   <= col + 1'b1;
                        ray_angle <= next_angle;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_slice_column_sequencer.sv
// ==== tb_slice_column_sequencer : scoreboard bench for slice_column_sequencer ====
// ==== rev 1.0                                                               ====
`default_nettype none

module tb_slice_column_sequencer;

    localparam int NUM_COLS = 160;
    localparam int PROJ_W   = 14;

    logic        clock = 1'b0;
    logic        reset, start;
    logic [16:0] player_angle;
    logic        busy, done, ray_valid, ray_ready;
    logic [16:0] ray_angle;
    logic [7:0]  ray_col;
    logic        hit_valid;
    logic [20:0] hit_dist_h, hit_dist_v;
    logic [16:0] beta_angle;
    logic [8:0]  cos_value;
    logic        slice_valid, slice_ready;
    logic [7:0]  slice_col, slice_height, slice_top;

    always #5 clock = ~clock;

    slice_column_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .player_angle(player_angle),
        .busy(busy), .done(done), .ray_valid(ray_valid), .ray_ready(ray_ready),
        .ray_angle(ray_angle), .ray_col(ray_col), .hit_valid(hit_valid),
        .hit_dist_h(hit_dist_h), .hit_dist_v(hit_dist_v), .beta_angle(beta_angle),
        .cos_value(cos_value), .slice_valid(slice_valid), .slice_ready(slice_ready),
        .slice_col(slice_col), .slice_height(slice_height), .slice_top(slice_top)
    );

    typedef struct {
        int col;
        int h;
        int t;
    } exp_t;

    // Hit pattern by column mod 5, with hand-computed height/top.
    int pat_h [5] = '{300, 100, 50, 0, 800};
    int pat_v [5] = '{200, 100, 70, 500, 400};
    int pat_c [5] = '{256, 256, 256, 256, 192};
    int pat_ht[5] = '{44, 88, 120, 120, 29};
    int pat_tp[5] = '{38, 16, 0, 0, 45};

    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   cyc = 0;
    int   frame_pa, exp_col, hit_cyc, done_cnt;
    int   ang_seen[NUM_COLS];
    int   beta_seen0;
    bit   stray_hit;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Wall engine: answers each ray two cycles after the handshake.
    initial begin
        int          pend, ph, pv, pc, k, ea;
        logic        prev_rv, prev_rr;
        logic [16:0] prev_ang;
        logic [7:0]  prev_rcol;
        exp_t        e;
        pend = 0; ph = 0; pv = 0; pc = 256;
        prev_rv = 0; prev_rr = 0; prev_ang = 0; prev_rcol = 0;
        hit_valid = 0; hit_dist_h = 0; hit_dist_v = 0; cos_value = 9'd256;
        forever begin
            @(negedge clock);
            hit_valid = 0;
            if (reset) begin
                pend = 0;
            end else begin
                if (pend == 1) begin
                    hit_valid = 1; hit_dist_h = 21'(ph); hit_dist_v = 21'(pv);
                    cos_value = 9'(pc); hit_cyc = cyc; pend = 0;
                end else if (pend > 1) begin
                    pend--;
                end
                if (stray_hit) begin
                    hit_valid = 1; hit_dist_h = 0; hit_dist_v = 0; stray_hit = 0;
                end
                if (ray_valid && prev_rv && !prev_rr) begin
                    chk("ray_hold_angle", ray_angle, prev_ang);
                    chk("ray_hold_col", ray_col, prev_rcol);
                end
                if (ray_valid && ray_ready) begin
                    k  = exp_col % 5;
                    ea = frame_pa + 7680 - exp_col * 96;
                    if (ea >= 92160) ea -= 92160;
                    else if (ea < 0) ea += 92160;
                    chk("ray_col", ray_col, exp_col);
                    chk("ray_angle", ray_angle, ea);
                    chk("beta_angle", $signed(beta_angle), exp_col * 96 - 7680);
                    if (exp_col < NUM_COLS) ang_seen[exp_col] = int'(ray_angle);
                    if (exp_col == 0) beta_seen0 = int'($signed(beta_angle));
                    e.col = exp_col; e.h = pat_ht[k]; e.t = pat_tp[k];
                    sb.push_back(e);
                    ph = pat_h[k]; pv = pat_v[k]; pc = pat_c[k];
                    pend = 2;
                    exp_col++;
                end
            end
            prev_rv = ray_valid; prev_rr = ray_ready;
            prev_ang = ray_angle; prev_rcol = ray_col;
        end
    end

    // Slice monitor: pops the scoreboard on every slice handshake.
    initial begin
        logic       prev_sv, prev_sr;
        logic [7:0] p_col, p_h, p_t;
        int         last_hs_cyc, last_hs_col;
        exp_t       e;
        prev_sv = 0; prev_sr = 0; p_col = 0; p_h = 0; p_t = 0;
        last_hs_cyc = -10; last_hs_col = -1; done_cnt = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (slice_valid && !prev_sv)
                    chk("slice_latency", cyc - hit_cyc, PROJ_W + 2);
                if (slice_valid && prev_sv && !prev_sr) begin
                    chk("slice_hold_col", slice_col, p_col);
                    chk("slice_hold_height", slice_height, p_h);
                    chk("slice_hold_top", slice_top, p_t);
                end
                if (slice_valid && slice_ready) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL slice_unexpected actual=col%0d required=none", slice_col);
                    end else begin
                        e = sb.pop_front();
                        chk("slice_col", slice_col, e.col);
                        chk("slice_height", slice_height, e.h);
                        chk("slice_top", slice_top, e.t);
                    end
                    last_hs_cyc = cyc;
                    last_hs_col = int'(slice_col);
                end
                if (done) begin
                    done_cnt++;
                    chk("done_after_last_col", last_hs_col, NUM_COLS - 1);
                    chk("done_timing", cyc - last_hs_cyc, 1);
                    chk("busy_with_done", busy, 0);
                end
            end
            prev_sv = slice_valid; prev_sr = slice_ready;
            p_col = slice_col; p_h = slice_height; p_t = slice_top;
        end
    end

    task automatic run_start(input int pa);
        frame_pa = pa; exp_col = 0;
        player_angle = 17'(pa); start = 1;
        tick(1);
        start = 0; player_angle = 17'(45 << 8);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 8000) begin
            tick(1);
            n++;
        end
        if (done_cnt < target) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=%0d required=%0d", done_cnt, target);
        end
    endtask

    initial begin
        int n;
        reset = 1; start = 0; player_angle = 0; ray_ready = 1; slice_ready = 1;
        stray_hit = 0; frame_pa = 0; exp_col = 0; hit_cyc = 0; beta_seen0 = 0;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ray_valid", ray_valid, 0);
        chk("rst_slice_valid", slice_valid, 0);
        chk("rst_ray_angle", ray_angle, 0);
        chk("rst_ray_col", ray_col, 0);
        chk("rst_slice_col", slice_col, 0);
        chk("rst_slice_height", slice_height, 0);
        chk("rst_slice_top", slice_top, 0);
        reset = 0;
        tick(2);

        // Frame 1: heading 90 deg, no back-pressure
        run_start(90 << 8);
        chk("f1_busy", busy, 1);
        wait_done(1);
        chk("f1_col0_angle", ang_seen[0], 30720);
        chk("f1_col0_beta", beta_seen0, -7680);
        chk("f1_col159_angle", ang_seen[159], 15456);
        tick(5);
        chk("f1_done_once", done_cnt, 1);
        chk("f1_idle", busy, 0);

        // Frame 2: heading 350 deg, stray hit, start while busy, slice back-pressure
        ray_ready = 0;
        run_start(350 << 8);
        tick(3);
        stray_hit = 1;
        tick(3);
        chk("stray_hit_ignored", ray_valid, 1);
        player_angle = 17'(180 << 8); start = 1;
        tick(1);
        start = 0;
        tick(2);
        chk("start_busy_ignored", ray_col, 0);
        ray_ready = 1;
        n = 0;
        while (!(slice_valid && slice_col == 8'd2) && n < 500) begin
            tick(1);
            n++;
        end
        chk("bp_reach_col2", slice_col, 2);
        slice_ready = 0;
        tick(20);
        chk("bp_valid_held", slice_valid, 1);
        chk("bp_col_held", slice_col, 2);
        chk("bp_height_held", slice_height, 120);
        slice_ready = 1;
        wait_done(2);
        chk("f2_col0_angle", ang_seen[0], 5120);
        tick(5);

        // Reset while dividing: frame abandoned, no done
        run_start(90 << 8);
        n = 0;
        while (!hit_valid && n < 100) begin
            tick(1);
            n++;
        end
        chk("rd_hit_seen", hit_valid, 1);
        tick(2);
        reset = 1;
        tick(1);
        chk("rd_busy", busy, 0);
        chk("rd_ray_valid", ray_valid, 0);
        chk("rd_slice_valid", slice_valid, 0);
        chk("rd_done", done, 0);
        chk("rd_ray_angle", ray_angle, 0);
        chk("rd_slice_height", slice_height, 0);
        sb.delete();
        reset = 0;
        tick(40);
        chk("rd_no_done", done_cnt, 2);
        chk("rd_stays_idle", busy, 0);

        // Frame 3: heading 10 deg, last column wraps below zero
        run_start(10 << 8);
        wait_done(3);
        chk("f3_col0_angle", ang_seen[0], 10240);
        chk("f3_col159_angle", ang_seen[159], 87136);
        tick(5);
        chk("f3_done_count", done_cnt, 3);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/slice_column_sequencer.md
Name: slice_column_sequencer

Overview:
- Parametrised successor to the single-slice draw FSM. Sweeps every screen column for one frame.
- Per column it computes the ray angle and the fishbowl angle beta. It issues the ray to an external wall-intersection engine and takes the lower of the horizontal and vertical hit distances.
- It applies cos(beta) correction, then computes the projected wall height with an iterative restoring divider and clamps it.
- Sits between the frame controller (start/done) and the column drawer (slice valid/ready).

Parameters:
- NUM_COLS, 160, screen columns swept per frame.
- COL_W, 8, column index width.
- ANGLE_FRAC, 8, fractional bits of all angles (degrees, fixed point).
- ANGLE_W, 17, angle width (9 integer + ANGLE_FRAC).
- FOV_DEG, 60, horizontal field of view in degrees.
- DIST_W, 21, unsigned hit-distance width.
- COS_FRAC, 8, fractional bits of the cos LUT value.
- PROJ_CONST, 8896, projection constant (dividend).
- PROJ_W, 14, dividend width; also the divider iteration count.
- SCREEN_H, 120, screen height in pixels (height clamp).
- HEIGHT_W, 8, height/top output width.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  1-cycle pulse; begins a frame sweep.
- player_angle  in  ANGLE_W  player heading, 0 <= a < 360<<ANGLE_FRAC.
- busy  out  1  high from start acceptance until done.
- done  out  1  1-cycle pulse after the last column is emitted.
- ray_valid  out  1  ray request valid.
- ray_ready  in  1  engine accepts the ray.
- ray_angle  out  ANGLE_W  wrapped ray angle.
- ray_col  out  COL_W  column of the ray.
- hit_valid  in  1  engine result valid (1-cycle pulse).
- hit_dist_h  in  DIST_W  horizontal-grid distance, unsigned.
- hit_dist_v  in  DIST_W  vertical-grid distance, unsigned.
- beta_angle  out  ANGLE_W  signed beta driven to the combinational cos LUT.
- cos_value  in  COS_FRAC+1  unsigned cos(beta), same-cycle LUT return.
- slice_valid  out  1  slice result valid.
- slice_ready  in  1  drawer accepts the slice.
- slice_col  out  COL_W  column index.
- slice_height  out  HEIGHT_W  clamped projected height.
- slice_top  out  HEIGHT_W  (SCREEN_H - height) >> 1.

Behaviour:
- Reset (synchronous, active-high, takes priority in any state): FSM goes to IDLE. busy, done, ray_valid and slice_valid go to 0. ray_angle, ray_col, slice_col, slice_height, slice_top and the column counter go to 0. Reset mid-sweep abandons the frame and no done pulse is issued.
- Step constant: STEP = FOV_DEG*2^ANGLE_FRAC / NUM_COLS (default 96 = 0.375 deg). HALF = (FOV_DEG/2) << ANGLE_FRAC.
- Per column c:
  - beta = c*STEP - HALF (signed).
  - raw = player_angle + HALF - c*STEP.
  - If raw >= 360<<F, subtract 360<<F. If raw < 0, add 360<<F. The result drives ray_angle.
- States:
  - IDLE: on start, latch player_angle, clear col, set busy, go to ISSUE. start is ignored in every other state.
  - ISSUE: ray_valid=1 with ray_angle and ray_col stable. On ray_valid && ray_ready go to WAIT_HIT.
  - WAIT_HIT: on hit_valid, register dmin = min(hit_dist_h, hit_dist_v); on a tie take h. Go to CORRECT. hit_valid in any other state is ignored.
  - CORRECT: one cycle. corr = (dmin * cos_value) >> COS_FRAC, truncating; the product is DIST_W+COS_FRAC+1 bits wide. beta_angle is held valid throughout the column. Load the divider, go to DIVIDE.
  - DIVIDE: restoring division PROJ_CONST / corr, one quotient bit per cycle, exactly PROJ_W cycles.
    - If corr == 0, skip the division and force height = SCREEN_H (same cycle count).
    - Quotient > SCREEN_H clamps to SCREEN_H.
    - Go to EMIT.
  - EMIT: slice_valid=1 with slice_col, slice_height and slice_top stable until slice_ready.
    - On handshake, if col == NUM_COLS-1: pulse done, clear busy, go to IDLE.
    - Otherwise increment col and go to ISSUE.
- Latency: ray handshake + engine latency + 1 + PROJ_W + slice handshake. With zero back-pressure the sequencer adds PROJ_W+3 cycles per column.
- Back-pressure: valids never drop, and their payloads never change, while waiting for ready.

Test Plan:
- Column 0 angle: player_angle=90<<8, start, ray_ready tied 1 -> first ray_angle=30720, ray_col=0, beta_angle=-7680.
- Last column angle: player_angle=90<<8, column 159 -> ray_angle=15456; done pulses once after the 160th slice handshake and busy falls in the same cycle.
- Wrap-around: player_angle=350<<8, col 0 -> 5120. player_angle=10<<8, col 159 -> 87136.
- Distance selection and height: cos=256, h=300, v=200 -> slice_height=44, slice_top=38. h=v=100 -> height 88, top 16.
- Clamp and divide-by-zero: dmin=50 -> 120/0. dmin=0 -> 120/0, with no hang and the same cycle count.
- Back-pressure, ignores and reset: hold slice_ready=0 for 20 cycles -> payload stable. hit_valid pulsed during ISSUE -> ignored. start while busy -> ignored. reset asserted in DIVIDE -> next cycle IDLE, all valids 0, no done.
